// File: rtl/prim_esc_pkg.sv
// Escalation link types shared by the escalation sender and receiver.
package prim_esc_pkg;

    // Sender -> receiver differential escalation pair.
    typedef struct packed {
        logic esc_p;
        logic esc_n;
    } esc_tx_t;

    // Receiver -> sender differential response pair.
    typedef struct packed {
        logic resp_p;
        logic resp_n;
    } esc_rx_t;

    localparam esc_tx_t EscTxDefault = '{esc_p: 1'b0, esc_n: 1'b1};
    localparam esc_rx_t EscRxDefault = '{resp_p: 1'b0, resp_n: 1'b1};

endpackage

// File: rtl/prim_buf.sv
// Keep-through buffer: marks a signal that synthesis must not merge or optimise away.
module prim_buf #(
    parameter int Width = 1
) (
    input  logic [Width-1:0] in_i,
    output logic [Width-1:0] out_o
);

    assign out_o = in_i;

endmodule

// File: rtl/prim_diff_decode.sv
// Differential pair decoder: recovers the level from the positive rail and
// flags a signal-integrity error whenever both rails carry the same value.
// Only the synchronous flavour is provided; the pair must already be in the
// local clock domain.
module prim_diff_decode #(
    parameter bit AsyncOn = 1'b0
) (
    input  logic diff_pi,
    input  logic diff_ni,
    output logic level_o,
    output logic sigint_o
);

    if (AsyncOn) begin : g_async
        // No synchroniser in this flavour: report a permanent integrity error
        // so a mis-parameterised instance cannot silently pass traffic.
        assign level_o  = 1'b0;
        assign sigint_o = 1'b1;
    end else begin : g_sync
        assign level_o  = diff_pi;
        assign sigint_o = ~(diff_pi ^ diff_ni);
    end

endmodule

// File: rtl/prim_esc_sender.sv
// Escalation sender: drives the esc_p/n pair (multi-cycle escalation pulses,
// single-cycle ping pulses) and checks the toggling response on resp_p/n.
//
// state          | meaning
// ---------------+-----------------------------------------------------------
// Idle           | no check in progress, response ignored
// CheckEscRespHi | escalating, response must be 1 this cycle
// CheckEscRespLo | escalating, response must be 0 this cycle
// CheckPingResp0 | ping sent, expecting 1
// CheckPingResp1 | ping sent, expecting 0
// CheckPingResp2 | ping sent, expecting 1
// CheckPingResp3 | ping sent, expecting 0; success completes the ping
module prim_esc_sender
    import prim_esc_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    ping_req_i,
    output logic    ping_ok_o,
    output logic    integ_fail_o,
    input  logic    esc_req_i,
    input  esc_rx_t esc_rx_i,
    output esc_tx_t esc_tx_o
);

    typedef enum logic [4:0] {
        Idle           = 5'b00101,
        CheckEscRespLo = 5'b11010,
        CheckEscRespHi = 5'b01111,
        CheckPingResp0 = 5'b10100,
        CheckPingResp1 = 5'b00011,
        CheckPingResp2 = 5'b11101,
        CheckPingResp3 = 5'b01000
    } state_e;

    state_e state_q, state_d;
    logic   esc_req_q, ping_req_q, ping_ok_seen_q;
    logic   ping_pulse, esc_p_raw, esc_n_raw, esc_p_buf, esc_n_buf;
    logic   resp, sigint, ping_ok, integ_fail, esc_ping_ok;

    assign ping_pulse = ping_req_i & ~ping_req_q;

    // The delayed request stretches every escalation to at least two cycles,
    // while a ping stays one cycle. Reset forces the pair to its idle value
    // immediately, even if a request is still present on the inputs.
    assign esc_p_raw = rst_ni & (esc_req_i | esc_req_q | ping_pulse);
    assign esc_n_raw = ~esc_p_raw;

    prim_buf #(.Width(1)) u_buf_p (.in_i(esc_p_raw), .out_o(esc_p_buf));
    prim_buf #(.Width(1)) u_buf_n (.in_i(esc_n_raw), .out_o(esc_n_buf));

    assign esc_tx_o.esc_p = esc_p_buf;
    assign esc_tx_o.esc_n = esc_n_buf;

    prim_diff_decode #(.AsyncOn(1'b0)) u_decode (
        .diff_pi  (esc_rx_i.resp_p),
        .diff_ni  (esc_rx_i.resp_n),
        .level_o  (resp),
        .sigint_o (sigint)
    );

    // A running escalation proves the link, so it answers a pending ping once.
    assign esc_ping_ok = ping_pulse | (ping_req_i & ~ping_ok_seen_q);

    // Next-state and output decode; integrity errors override everything.
    always_comb begin
        state_d    = state_q;
        ping_ok    = 1'b0;
        integ_fail = 1'b0;
        case (state_q)
            Idle: begin
                if (esc_req_i) begin
                    state_d = CheckEscRespHi;
                end else if (ping_pulse) begin
                    state_d = CheckPingResp0;
                end
            end
            CheckEscRespHi: begin
                if (!esc_req_i) begin
                    state_d = Idle;
                end else if (!resp) begin
                    state_d    = Idle;
                    integ_fail = 1'b1;
                end else begin
                    state_d = CheckEscRespLo;
                    ping_ok = esc_ping_ok;
                end
            end
            CheckEscRespLo: begin
                if (!esc_req_i) begin
                    state_d = Idle;
                end else if (resp) begin
                    state_d    = Idle;
                    integ_fail = 1'b1;
                end else begin
                    state_d = CheckEscRespHi;
                    ping_ok = esc_ping_ok;
                end
            end
            // An escalation arriving mid-ping takes over in the phase the
            // receiver is already toggling in.
            CheckPingResp0: begin
                if (esc_req_i) begin
                    state_d = CheckEscRespLo;
                end else if (!resp) begin
                    state_d    = Idle;
                    integ_fail = 1'b1;
                end else begin
                    state_d = CheckPingResp1;
                end
            end
            CheckPingResp1: begin
                if (esc_req_i) begin
                    state_d = CheckEscRespHi;
                end else if (resp) begin
                    state_d    = Idle;
                    integ_fail = 1'b1;
                end else begin
                    state_d = CheckPingResp2;
                end
            end
            CheckPingResp2: begin
                if (esc_req_i) begin
                    state_d = CheckEscRespLo;
                end else if (!resp) begin
                    state_d    = Idle;
                    integ_fail = 1'b1;
                end else begin
                    state_d = CheckPingResp3;
                end
            end
            CheckPingResp3: begin
                if (esc_req_i) begin
                    state_d = CheckEscRespHi;
                end else if (resp) begin
                    state_d    = Idle;
                    integ_fail = 1'b1;
                end else begin
                    state_d = Idle;
                    ping_ok = 1'b1;
                end
            end
            default: state_d = Idle;
        endcase

        if (sigint && (state_q != Idle || esc_req_i || ping_req_i)) begin
            state_d    = Idle;
            ping_ok    = 1'b0;
            integ_fail = 1'b1;
        end
    end

    assign ping_ok_o    = rst_ni & ping_ok;
    assign integ_fail_o = rst_ni & integ_fail;

    // State, request history and the one-ok-per-ping-request marker.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= Idle;
            esc_req_q      <= 1'b0;
            ping_req_q     <= 1'b0;
            ping_ok_seen_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            esc_req_q      <= esc_req_i;
            ping_req_q     <= ping_req_i;
            ping_ok_seen_q <= ping_req_i & (ping_ok_seen_q | ping_ok);
        end
    end

    a_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !$isunknown({esc_tx_o, ping_ok_o, integ_fail_o}));

    a_ok_fail_excl: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(ping_ok_o && integ_fail_o));

    a_esc_min_len: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ($rose(esc_tx_o.esc_p) && !ping_pulse) |=> esc_tx_o.esc_p);

endmodule

// File: tb/tb_prim_esc_sender.sv
// Bench for prim_esc_sender: an ideal receiver model answers on resp_p/n,
// optionally overridden per cycle to inject protocol or integrity faults.
module tb_prim_esc_sender;
    import prim_esc_pkg::*;

    logic    clk = 1'b0;
    logic    rst_n = 1'b0;
    logic    ping_req = 1'b0;
    logic    esc_req = 1'b0;
    logic    ping_ok, integ_fail;
    esc_rx_t esc_rx;
    esc_tx_t esc_tx;

    logic ovr_en = 1'b0, ovr_p = 1'b0, ovr_n = 1'b0;
    logic rx_p, rx_prev;
    int   rx_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      tag;
        logic       esc;
        logic       ping;
        logic       ovr;
        logic       op;
        logic       on;
        logic [3:0] exp;   // {esc_p, esc_n, ping_ok, integ_fail}
    } vec_t;

    typedef struct {
        string      tag;
        logic [3:0] exp;
    } sb_t;

    vec_t tbl[$];
    sb_t  sbq[$];

    always #5 clk = ~clk;

    prim_esc_sender dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .ping_req_i   (ping_req),
        .ping_ok_o    (ping_ok),
        .integ_fail_o (integ_fail),
        .esc_req_i    (esc_req),
        .esc_rx_i     (esc_rx),
        .esc_tx_o     (esc_tx)
    );

    // Ideal receiver: answers 1,0,1,0 after a ping, toggles while escalated.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_p    <= 1'b0;
            rx_prev <= 1'b0;
            rx_cnt  <= 0;
        end else begin
            rx_prev <= esc_tx.esc_p;
            if (esc_tx.esc_p && !rx_prev) begin
                rx_p   <= 1'b1;
                rx_cnt <= 3;
            end else if (esc_tx.esc_p) begin
                rx_p   <= ~rx_p;
                rx_cnt <= 0;
            end else if (rx_cnt > 0) begin
                rx_p   <= ~rx_p;
                rx_cnt <= rx_cnt - 1;
            end else begin
                rx_p <= 1'b0;
            end
        end
    end

    assign esc_rx.resp_p = ovr_en ? ovr_p : rx_p;
    assign esc_rx.resp_n = ovr_en ? ovr_n : ~rx_p;

    function automatic vec_t mk(input string tag, input logic esc, input logic ping,
                                input logic ovr, input logic op, input logic on,
                                input logic ep, input logic ok, input logic fl);
        vec_t v;
        v.tag  = tag;
        v.esc  = esc;
        v.ping = ping;
        v.ovr  = ovr;
        v.op   = op;
        v.on   = on;
        v.exp  = {ep, ~ep, ok, fl};
        return v;
    endfunction

    function automatic void add(input string tag, input logic esc, input logic ping,
                                input logic ovr, input logic op, input logic on,
                                input logic ep, input logic ok, input logic fl);
        tbl.push_back(mk(tag, esc, ping, ovr, op, on, ep, ok, fl));
    endfunction

    function automatic void add_idle(input int n);
        for (int i = 0; i < n; i++) add("idle", 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic check(input string tag, input logic [3:0] exp);
        logic [3:0] act;
        act = {esc_tx.esc_p, esc_tx.esc_n, ping_ok, integ_fail};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: {esc_p,esc_n,ping_ok,integ_fail} got %b expected %b",
                     tag, act, exp);
        end
    endtask

    task automatic drive_row(input vec_t r);
        sb_t s;
        @(posedge clk);
        #1;
        esc_req  = r.esc;
        ping_req = r.ping;
        ovr_en   = r.ovr;
        ovr_p    = r.op;
        ovr_n    = r.on;
        sbq.push_back('{tag: r.tag, exp: r.exp});
        @(negedge clk);
        s = sbq.pop_front();
        check(s.tag, s.exp);
    endtask

    task automatic run_ping_ok(input string tag);
        drive_row(mk({tag, "_c0"}, 0, 1, 0, 0, 0, 1, 0, 0));
        drive_row(mk({tag, "_c1"}, 0, 1, 0, 0, 0, 0, 0, 0));
        drive_row(mk({tag, "_c2"}, 0, 1, 0, 0, 0, 0, 0, 0));
        drive_row(mk({tag, "_c3"}, 0, 1, 0, 0, 0, 0, 0, 0));
        drive_row(mk({tag, "_c4"}, 0, 1, 0, 0, 0, 0, 1, 0));
        drive_row(mk({tag, "_c5"}, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        // Reset values, including with requests present during reset.
        #2;
        check("reset_vals", 4'b0100);
        esc_req  = 1'b1;
        ping_req = 1'b1;
        #1;
        check("reset_gated", 4'b0100);
        esc_req  = 1'b0;
        ping_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Ping answered correctly: ok on cycle 4.
        add("ping_c0", 0, 1, 0, 0, 0, 1, 0, 0);
        add("ping_c1", 0, 1, 0, 0, 0, 0, 0, 0);
        add("ping_c2", 0, 1, 0, 0, 0, 0, 0, 0);
        add("ping_c3", 0, 1, 0, 0, 0, 0, 0, 0);
        add("ping_c4", 0, 1, 0, 0, 0, 0, 1, 0);
        add("ping_c5", 0, 0, 0, 0, 0, 0, 0, 0);
        add_idle(4);
        // Ten-cycle escalation: esc_p stretched by one cycle, no failure.
        for (int i = 0; i < 10; i++) add("esc_long", 1, 0, 0, 0, 0, 1, 0, 0);
        add("esc_long_tail", 0, 0, 0, 0, 0, 1, 0, 0);
        add("esc_long_end", 0, 0, 0, 0, 0, 0, 0, 0);
        add_idle(4);
        // Single-cycle escalation request still yields a two-cycle pulse.
        add("esc1_c0", 1, 0, 0, 0, 0, 1, 0, 0);
        add("esc1_c1", 0, 0, 0, 0, 0, 1, 0, 0);
        add("esc1_c2", 0, 0, 0, 0, 0, 0, 0, 0);
        add_idle(4);
        // Ping with missing first answer.
        add("pbad0_c0", 0, 1, 0, 0, 0, 1, 0, 0);
        add("pbad0_c1", 0, 1, 1, 0, 1, 0, 0, 1);
        add("pbad0_c2", 0, 0, 0, 0, 0, 0, 0, 0);
        add_idle(4);
        // Ping with wrong last answer.
        add("pbad3_c0", 0, 1, 0, 0, 0, 1, 0, 0);
        add("pbad3_c1", 0, 1, 0, 0, 0, 0, 0, 0);
        add("pbad3_c2", 0, 1, 0, 0, 0, 0, 0, 0);
        add("pbad3_c3", 0, 1, 0, 0, 0, 0, 0, 0);
        add("pbad3_c4", 0, 1, 1, 1, 0, 0, 0, 1);
        add("pbad3_c5", 0, 0, 0, 0, 0, 0, 0, 0);
        add_idle(4);
        // Integrity error during escalation: flagged, esc_p unaffected.
        add("sig_c0", 1, 0, 0, 0, 0, 1, 0, 0);
        add("sig_c1", 1, 0, 1, 1, 1, 1, 0, 1);
        add("sig_c2", 0, 0, 0, 0, 0, 1, 0, 0);
        add("sig_c3", 0, 0, 0, 0, 0, 0, 0, 0);
        add_idle(4);
        // Integrity error with nothing active is ignored.
        add("sig_idle", 0, 0, 1, 1, 1, 0, 0, 0);
        add("sig_idle_z", 0, 0, 1, 0, 0, 0, 0, 0);
        add_idle(4);
        // Escalation aborts a ping; escalation itself answers the ping once.
        add("abort_c0", 0, 1, 0, 0, 0, 1, 0, 0);
        add("abort_c1", 0, 1, 0, 0, 0, 0, 0, 0);
        add("abort_c2", 1, 1, 0, 0, 0, 1, 0, 0);
        add("abort_c3", 1, 1, 0, 0, 0, 1, 1, 0);
        add("abort_c4", 1, 1, 0, 0, 0, 1, 0, 0);
        add("abort_c5", 1, 0, 0, 0, 0, 1, 0, 0);
        add("abort_c6", 0, 0, 0, 0, 0, 1, 0, 0);
        add("abort_c7", 0, 0, 0, 0, 0, 0, 0, 0);
        add_idle(4);

        foreach (tbl[i]) drive_row(tbl[i]);

        // Reset during CheckPingResp2, then a fresh ping completes normally.
        drive_row(mk("rst_c0", 0, 1, 0, 0, 0, 1, 0, 0));
        drive_row(mk("rst_c1", 0, 1, 0, 0, 0, 0, 0, 0));
        drive_row(mk("rst_c2", 0, 1, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid", 4'b0100);
        ping_req = 1'b0;
        @(negedge clk);
        check("rst_hold", 4'b0100);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_ping_ok("post_rst");

        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
